// File: rtl/pc_flow_monitor.sv
// Control-flow monitor: samples the fetch PC, logs every non-sequential step into a trace FIFO,
// and ends in DONE at END_ADDR or TIMEOUT. Optional macro PFM_OVERWRITE_EN keeps newest entries on overflow.
module pc_flow_monitor #(
  parameter int PC_W        = 12,
  parameter int TRACE_DEPTH = 8,
  parameter int END_ADDR    = 24,
  parameter int TIMEOUT     = 2000,
  parameter int CNT_W       = 16
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         pc_valid_i,
  input  logic [PC_W-1:0]              pc_i,
  input  logic                         rd_en_i,
  output logic                         rd_valid_o,
  output logic [PC_W-1:0]              rd_from_o,
  output logic [PC_W-1:0]              rd_to_o,
  output logic [$clog2(TRACE_DEPTH):0] trace_count_o,
  output logic                         overflow_o,
  output logic [CNT_W-1:0]             jump_count_o,
  output logic [CNT_W-1:0]             sample_count_o,
  output logic [1:0]                   state_o,
  output logic                         done_o,
  output logic                         timeout_o
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_DONE    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_e;

  state_e                state_q;
  logic [PC_W-1:0]       prev_pc_q;
  logic [CNT_W-1:0]      jump_q;
  logic [CNT_W-1:0]      sample_q;
  logic [CW-1:0]         count_q;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic                  overflow_q;
  logic                  rd_valid_q;
  logic [PC_W-1:0]       rd_from_q;
  logic [PC_W-1:0]       rd_to_q;
  logic [2*PC_W-1:0]     mem_q [TRACE_DEPTH];

  logic [PC_W-1:0]       seq_pc_s;
  logic                  jump_s;
  logic                  is_end_s;
  logic                  full_s;
  logic                  pop_s;
  logic                  wr_s;
  logic                  drop_oldest_s;
  logic [CW-1:0]         count_d;
  logic [CNT_W-1:0]      jump_d;
  logic [CNT_W-1:0]      sample_d;

  // Sequential successor wraps at 2^PC_W, so max->0 is not a jump.
  assign seq_pc_s = prev_pc_q + PC_W'(1);
  assign jump_s   = pc_valid_i && (state_q == ST_RUN) && (pc_i != seq_pc_s);
  assign is_end_s = (pc_i == PC_W'(END_ADDR));
  assign full_s   = (count_q == CW'(TRACE_DEPTH));
  assign pop_s    = rd_en_i && (count_q != '0);

`ifdef PFM_OVERWRITE_EN
  assign wr_s          = jump_s;
  assign drop_oldest_s = jump_s && full_s && !pop_s;
`else
  assign wr_s          = jump_s && (!full_s || pop_s);
  assign drop_oldest_s = 1'b0;
`endif

  assign count_d  = count_q + CW'(wr_s && !drop_oldest_s) - CW'(pop_s);
  assign jump_d   = (jump_q == '1) ? jump_q : jump_q + CNT_W'(1);
  assign sample_d = (sample_q == '1) ? sample_q : sample_q + CNT_W'(1);

  always_ff @(posedge clock_i) begin
    if (reset_i && wr_s) begin
      mem_q[wr_ptr_q] <= {prev_pc_q, pc_i};
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q    <= ST_IDLE;
      prev_pc_q  <= '0;
      jump_q     <= '0;
      sample_q   <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_from_q  <= '0;
      rd_to_q    <= '0;
    end else begin
      count_q    <= count_d;
      rd_valid_q <= pop_s;
      if (wr_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s || drop_oldest_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (jump_s && full_s && !pop_s) overflow_q <= 1'b1;
      // The read sees the pre-write slot, so a full push+pop returns the old oldest entry.
      if (pop_s) begin
        rd_from_q <= mem_q[rd_ptr_q][2*PC_W-1:PC_W];
        rd_to_q   <= mem_q[rd_ptr_q][PC_W-1:0];
      end
      case (state_q)
        ST_IDLE: begin
          if (pc_valid_i) begin
            prev_pc_q <= pc_i;
            state_q   <= is_end_s ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (pc_valid_i) begin
            prev_pc_q <= pc_i;
            sample_q  <= sample_d;
            if (jump_s) jump_q <= jump_d;
            if (is_end_s) state_q <= ST_DONE;
            else if (sample_d == CNT_W'(TIMEOUT)) state_q <= ST_TIMEOUT;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign rd_valid_o     = rd_valid_q;
  assign rd_from_o      = rd_from_q;
  assign rd_to_o        = rd_to_q;
  assign trace_count_o  = count_q;
  assign overflow_o     = overflow_q;
  assign jump_count_o   = jump_q;
  assign sample_count_o = sample_q;
  assign state_o        = state_q;
  assign done_o         = (state_q == ST_DONE);
  assign timeout_o      = (state_q == ST_TIMEOUT);

endmodule
